// File: rtl/mfcc_frame_scheduler.sv
// mfcc_frame_scheduler
//
// Framing controller at the front of the MFCC pipeline. Buffers the 16-bit PCM
// stream in a ring buffer and cuts it into overlapping frames of FRAME_LEN
// samples, advancing the frame base by HOP_LEN per frame. Each frame is handed
// to the Hamming windower as: start pulse, then one sample per valid/ack
// handshake, then a wait for the windower's done before the hop is released.
//
// Optional feature macro: MFCC_FRAME_TIMEOUT_EN
//   defined   - watchdog in WAIT_DONE; after TIMEOUT_CYCLES without done it
//               pulses timeout_o and returns to IDLE without advancing, so the
//               same frame is retried.
//   undefined - no watchdog, timeout_o tied low, WAIT_DONE waits forever.
//
// Ports:
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   enable_i        - allow new frames to start
//   sample_i        - signed PCM input sample
//   sample_valid_i  - write sample_i this cycle
//   overflow_o      - one-cycle pulse per dropped input sample
//   win_start_o     - one-cycle frame start pulse to the windower
//   win_valid_o     - win_sample_o/win_ptr_o hold the current frame sample
//   win_rd_en_i     - windower acknowledge (transfer = valid & rd_en)
//   win_sample_o    - frame sample presented to the windower
//   win_ptr_o       - index of the presented sample within the frame
//   win_done_i      - windower finished the frame
//   frame_count_o   - completed frames, wraps modulo 2^16
//   busy_o          - high whenever the FSM is not idle
//   timeout_o       - one-cycle pulse on watchdog abort
module mfcc_frame_scheduler #(
    parameter int unsigned FRAME_LEN      = 306,
    parameter int unsigned HOP_LEN        = 153,
    parameter int unsigned BUF_DEPTH      = 512,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i,
    output logic        overflow_o,
    output logic        win_start_o,
    output logic        win_valid_o,
    input  logic        win_rd_en_i,
    output logic [15:0] win_sample_o,
    output logic [8:0]  win_ptr_o,
    input  logic        win_done_i,
    output logic [15:0] frame_count_o,
    output logic        busy_o,
    output logic        timeout_o
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    // One extra pointer bit distinguishes a full ring from an empty one.
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFetch,
        StPresent,
        StWaitDone,
        StAdvance
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, base_q, occupancy;
    logic [8:0]    idx_q, idx_d;
    logic [15:0]   rd_data_q, win_sample_q;
    logic [8:0]    win_ptr_q;
    logic [15:0]   frame_count_q;
    logic          overflow_q;
    logic          full, wr_en, rd_en;
    logic [AW-1:0] rd_addr;

    assign occupancy = wr_ptr_q - base_q;
    // Occupancy is measured from the frame base, so a full ring drops the
    // sample instead of overwriting anything the current frame still needs.
    assign full      = (occupancy == PW'(BUF_DEPTH));
    assign wr_en     = sample_valid_i && !full;

    // Ring storage: no reset on the RAM or its read register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= sample_i;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

`ifdef MFCC_FRAME_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            wr_ptr_q      <= '0;
            base_q        <= '0;
            win_sample_q  <= '0;
            win_ptr_q     <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= sample_valid_i && full;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            // Write and hop may coincide; both pointers update independently.
            if (state_q == StAdvance) begin
                base_q        <= base_q + PW'(HOP_LEN);
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (state_q == StFetch) begin
                win_sample_q <= rd_data_q;
                win_ptr_q    <= idx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd_en   = 1'b0;
        rd_addr = base_q[AW-1:0] + AW'(idx_q);
`ifdef MFCC_FRAME_TIMEOUT_EN
        cnt_d     = '0;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (enable_i && (occupancy >= PW'(FRAME_LEN))) begin
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                rd_en   = 1'b1;
                state_d = StFetch;
            end
            StFetch: begin
                state_d = StPresent;
            end
            StPresent: begin
                if (win_rd_en_i) begin
                    if (idx_q == 9'(FRAME_LEN - 1)) begin
                        state_d = StWaitDone;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        rd_en   = 1'b1;
                        rd_addr = base_q[AW-1:0] + AW'(idx_q) + AW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StWaitDone: begin
                if (win_done_i) begin
                    state_d = StAdvance;
                end
`ifdef MFCC_FRAME_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort without hopping so the same frame is retried.
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            StAdvance: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign overflow_o    = overflow_q;
    assign win_start_o   = (state_q == StStart);
    assign win_valid_o   = (state_q == StPresent);
    assign win_sample_o  = win_sample_q;
    assign win_ptr_o     = win_ptr_q;
    assign frame_count_o = frame_count_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: doc/mfcc_frame_scheduler.md
# mfcc_frame_scheduler

Framing controller at the front of the MFCC pipeline. It buffers the incoming 16-bit PCM stream in an internal ring buffer and cuts it into overlapping frames of `FRAME_LEN` samples, advancing by `HOP_LEN`. For each frame it sequences the Hamming windowing stage: a start pulse, then the frame's samples one at a time over a valid/acknowledge handshake, then it waits for that stage's done before releasing the hop.

## Interface
- `FRAME_LEN`, 306: samples per frame.
- `HOP_LEN`, 153: samples the frame base advances per frame; constraint 1..`FRAME_LEN`.
- `BUF_DEPTH`, 512: ring depth; power of two, ≥ `FRAME_LEN`.
- `TIMEOUT_CYCLES`, 4096: done watchdog limit (macro-dependent).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable_i` in 1: allow new frames to start.
- `sample_i` in 16: signed PCM sample.
- `sample_valid_i` in 1: write `sample_i` this cycle.
- `overflow_o` out 1: one-cycle pulse per dropped input sample.
- `win_start_o` out 1: one-cycle frame start pulse to the windower.
- `win_valid_o` out 1: `win_sample_o` holds the current frame sample.
- `win_rd_en_i` in 1: windower acknowledge; a transfer occurs when `win_valid_o` and `win_rd_en_i` are both high.
- `win_sample_o` out 16: signed frame sample.
- `win_ptr_o` out 9: index of the presented sample within the frame (0..`FRAME_LEN`-1).
- `win_done_i` in 1: windower finished the frame.
- `frame_count_o` out 16: completed frames; wraps modulo 2^16.
- `busy_o` out 1: high in every state except IDLE.
- `timeout_o` out 1: one-cycle pulse on watchdog abort.

## Operation
- **Pointers.** Write pointer `wr_ptr` and frame base `base` are log2(`BUF_DEPTH`)+1 bits wide. Occupancy is `wr_ptr - base`, modulo 2^(log2+1).
- **Writes.** When `sample_valid_i` is high and occupancy < `BUF_DEPTH`, store the sample at `wr_ptr` and increment `wr_ptr`. When occupancy = `BUF_DEPTH`, drop the sample and pulse `overflow_o`. Writes are accepted in every state.
- **States:** IDLE, START, FETCH, PRESENT, WAIT_DONE, ADVANCE.
- **IDLE → START** when `enable_i` is high and occupancy ≥ `FRAME_LEN`. Clear the frame index `idx` to 0.
- **START.** Pulse `win_start_o` for one cycle. Issue the synchronous buffer read at `base + idx`. Go to FETCH.
- **FETCH.** Read data returns. Register it into `win_sample_o` and set `win_ptr_o = idx`. Go to PRESENT.
- **PRESENT.** Hold `win_valid_o` high until a transfer occurs. On transfer:
  - If `idx = FRAME_LEN-1`, go to WAIT_DONE.
  - Otherwise increment `idx`, issue the next read, and go to FETCH.
- **WAIT_DONE → ADVANCE** on `win_done_i`.
- **ADVANCE.** `base += HOP_LEN`; `frame_count_o += 1`. Return to IDLE.
- A `win_done_i` pulse received outside WAIT_DONE is ignored.
- A write in the same cycle as ADVANCE is accepted; both pointer updates take effect.
- Samples of the current frame are protected until ADVANCE. Writes can never overwrite them, only be dropped.

## Timing
- **Reset values.** All outputs are 0. `wr_ptr`, `base`, `idx` and `frame_count_o` are 0, and the state is IDLE. Buffer RAM contents are not cleared.
- **Reset mid-frame.** The frame is abandoned, all buffered samples are discarded, and no done is expected afterwards.
- **Start latency.** The cycle after occupancy reaches `FRAME_LEN` (registered), `win_start_o` rises. `win_valid_o` rises 2 cycles after `win_start_o`.
- **Valid timing.**
  - `win_valid_o` drops the cycle after every transfer. After a non-final transfer it is high again 2 cycles after that transfer, so throughput is at most one sample per 2 cycles.
  - Minimum frame duration from start pulse to last transfer is 2·`FRAME_LEN` cycles.
- **Stall.** While `win_valid_o` is high and `win_rd_en_i` is low, `win_sample_o` and `win_ptr_o` are held stable.
- **Completion.** `frame_count_o` updates 2 cycles after `win_done_i`. The earliest next start pulse is one cycle after that.

## Configuration
- **`MFCC_FRAME_TIMEOUT_EN` defined:** a counter runs in WAIT_DONE.
  - If `TIMEOUT_CYCLES` cycles pass without `win_done_i`, pulse `timeout_o`, skip ADVANCE (`base` and `frame_count_o` unchanged) and return to IDLE.
  - The same frame is then retried.
- **`MFCC_FRAME_TIMEOUT_EN` undefined:** no counter is built, `timeout_o` is tied to 0, and WAIT_DONE waits indefinitely.

## Test plan
- **First frame.** Push ramp samples 0..305 with `enable_i`=1 and `win_rd_en_i` always 1.
  - Required: one `win_start_o`; exactly 306 transfers with `win_sample_o` = `win_ptr_o` = 0..305.
  - Then `win_done_i` → `frame_count_o`=1, `busy_o`=0.
- **Overlap.** Push 153 more samples (306..458).
  - Required: the second frame transfers samples 153..458, and `frame_count_o`=2.
- **Stall.** Hold `win_rd_en_i`=0 for 10 cycles at index 40.
  - Required: `win_valid_o` stays 1 with `win_sample_o`=40 and `win_ptr_o`=40 throughout; the next transfer is index 40.
- **Overflow.** Never acknowledge; push 520 samples.
  - Required: exactly 8 `overflow_o` pulses and occupancy held at 512.
  - After the frame completes, the sample at index 153 is 153.
- **Reset mid-frame.** Assert `rst` at index 100.
  - Required: all outputs 0 the next cycle.
  - 306 new samples then produce a frame starting at the first new sample.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=16). Withhold `win_done_i`.
  - Required: `timeout_o` pulses 16 cycles after entering WAIT_DONE; `frame_count_o` unchanged; the same frame restarts.
